combo_score_keeper: RTL and testbench
=====================================

# combo_score_keeper

Parametrised BCD score keeper for the brick-breaker game core, sitting between the collision logic (hit/miss pulses) and the seven-segment/on-screen score display. Each hit carries a point value that is scaled by a combo multiplier which grows with consecutive hits and resets on a miss. Scaling is performed as repeated BCD addition through a small FSM with a one-deep pending slot. The block saturates at all-nines and keeps a high score that survives game restarts.

## Interface
- DIGITS, 3, number of BCD digits in score and high score (1..8)
- MAX_MULT, 4, maximum combo multiplier (1..9)
- COMBO_STEP, 5, consecutive accepted hits per multiplier increment (1..15)

- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- restartGame  in  1  synchronous game restart, level-sampled
- hit  in  1  one-cycle pulse: brick hit
- hitPoints  in  4  BCD point value of this hit, sampled with hit; values above 9 are treated as 9
- miss  in  1  one-cycle pulse: ball lost, clears the combo
- scoreBcd  out  4*DIGITS  current score, digit 0 (ones) in bits [3:0]
- highBcd  out  4*DIGITS  highest score since resetN
- multiplier  out  4  current combo multiplier (1..MAX_MULT)
- busy  out  1  FSM in ADD or pending slot occupied
- hitDropped  out  1  one-cycle pulse: hit lost because the pending slot was full
- saturated  out  1  sticky: score clamped at all-nines
- newHigh  out  1  sticky: high score beaten during this game

## Operation
- Reset (resetN low): scoreBcd=0, highBcd=0, comboCnt=0, multiplier=1, state IDLE, pending empty, busy=0, hitDropped=0, saturated=0, newHigh=0.
- comboCnt: counts accepted hits and saturates at COMBO_STEP*(MAX_MULT-1). multiplier = 1 + comboCnt/COMBO_STEP (registered output).
- Hit acceptance: latch pts = min(hitPoints,9) and mult = the multiplier value before this hit's increment. Then comboCnt += 1.
- FSM IDLE: a hit is latched into the working registers (cnt = mult) and the FSM goes to ADD.
- FSM ADD: each cycle, score += pts in BCD with a per-digit decimal carry, and cnt -= 1.
  - On the cycle with cnt==1, if pending is valid, load pending into the working registers and stay in ADD; otherwise go to IDLE.
- Hit while in ADD:
  - If pending is empty, store {pts, mult} in pending.
  - If pending is full, pulse hitDropped; comboCnt is unchanged.
- miss: comboCnt <= 0. A miss does not alter work already latched.
  - Simultaneous hit+miss: the hit is accepted with the pre-miss multiplier, then comboCnt=0.
- hitPoints=0: the hit is accepted, the combo increments, and the ADD cycles add 0.
- Saturation: if an add carries out of the top digit, scoreBcd <= all 9s and saturated <= 1. Later adds leave it at all 9s.
- High score: every cycle, if registered scoreBcd > highBcd (unsigned compare; valid for BCD), then highBcd <= scoreBcd and newHigh <= 1.
- restartGame: has priority over hit, miss and ADD.
  - Clears score, comboCnt, pending, state, saturated and newHigh.
  - highBcd is preserved.
  - A hit in the same cycle is discarded without a hitDropped pulse.

## Timing
- A hit sampled at edge E0 in IDLE moves the FSM to ADD at E0. Additions land at E1..E(mult), so the first score change is visible 2 edges after hit is asserted.
- A hit with mult=m holds busy for m cycles after acceptance; a queued hit follows back-to-back with no idle cycle.
- multiplier updates at the same edge that accepts the hit or miss.
- highBcd/newHigh lag scoreBcd by one cycle.
- hitDropped is high exactly one cycle, at the edge after the dropped hit.
- resetN is asynchronous and may assert mid-ADD. All state returns to reset values immediately, including highBcd.

## Test plan
- From reset, 5 isolated hits with hitPoints=1 -> scoreBcd=005, multiplier=2. A 6th hit with hitPoints=3 -> two ADD cycles, scoreBcd=011.
- Carry: score 098, multiplier 1, hit with hitPoints=5 -> scoreBcd=103 one ADD cycle later, no saturation.
- Saturation (DIGITS=3): score 997, hit with hitPoints=5 -> scoreBcd=999, saturated=1. A further hit leaves 999. restartGame -> score 000, saturated=0.
- Queueing: multiplier=3, three hits on consecutive cycles -> 1st processed, 2nd pending, 3rd dropped (hitDropped pulse, comboCnt +2 only). busy stays high for 6 cycles.
- Combo reset: multiplier=3, miss together with a hit of 2 points -> score +6, then multiplier=1. The next hit of 2 points adds 2.
- High score: reach 120, restartGame -> highBcd=120, scoreBcd=000, newHigh=0. Climb to 121 -> highBcd=121 and newHigh=1 one cycle after the score.

Source files
------------

// File: rtl/combo_score_keeper.sv
// BCD score keeper: combo-scaled hits are added as repeated BCD adds, one add per cycle.
// First score change 2 edges after hit; a one-deep pending slot absorbs one hit, further hits pulse hitDropped.
module combo_score_keeper #(
    parameter int DIGITS     = 3,
    parameter int MAX_MULT   = 4,
    parameter int COMBO_STEP = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  restartGame,
    input  logic                  hit,
    input  logic [3:0]            hitPoints,
    input  logic                  miss,
    output logic [4*DIGITS-1:0]   scoreBcd,
    output logic [4*DIGITS-1:0]   highBcd,
    output logic [3:0]            multiplier,
    output logic                  busy,
    output logic                  hitDropped,
    output logic                  saturated,
    output logic                  newHigh
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = 8;
    localparam logic [CW-1:0] COMBO_MAX = CW'(COMBO_STEP * (MAX_MULT - 1));
    localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {S_IDLE, S_ADD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    score_q, score_d;
    logic [W-1:0]    high_q, high_d;
    logic [CW-1:0]   combo_q, combo_d;
    logic [3:0]      mult_q, mult_d;
    logic [3:0]      pts_q, pts_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_vld_q, pend_vld_d;
    logic [3:0]      pend_pts_q, pend_pts_d;
    logic [3:0]      pend_mult_q, pend_mult_d;
    logic            dropped_q, dropped_d;
    logic            sat_q, sat_d;
    logic            new_high_q, new_high_d;

    logic [3:0]      pts_in;
    logic            hit_vld;
    logic            accept;
    logic            drop;
    logic            last_add;
    logic            high_gt;
    logic [W:0]      add_res;

    // Decimal add of a single digit value into the ones position; MSB is the carry out of the top digit.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [3:0] p);
        logic [W-1:0] sum;
        logic         c;
        logic [4:0]   s;
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + {4'd0, c};
            if (i == 0) begin
                s = s + {1'b0, p};
            end
            if (s > 5'd9) begin
                sum[4*i +: 4] = 4'(s - 5'd10);
                c = 1'b1;
            end else begin
                sum[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        return {c, sum};
    endfunction

    assign pts_in   = (hitPoints > 4'd9) ? 4'd9 : hitPoints;
    assign hit_vld  = hit && !restartGame;
    assign accept   = hit_vld && ((state_q == S_IDLE) || !pend_vld_q);
    assign drop     = hit_vld && (state_q == S_ADD) && pend_vld_q;
    assign last_add = (state_q == S_ADD) && (cnt_q == 4'd1);
    assign high_gt  = score_q > high_q;
    assign add_res  = bcd_add(score_q, pts_q);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restartGame) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) state_d = S_ADD;
                S_ADD:  if (last_add && !pend_vld_q && !accept) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        score_d     = score_q;
        combo_d     = combo_q;
        pts_d       = pts_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_pts_d  = pend_pts_q;
        pend_mult_d = pend_mult_q;
        dropped_d   = 1'b0;
        sat_d       = sat_q;
        high_d      = high_gt ? score_q : high_q;
        new_high_d  = new_high_q || high_gt;

        if (restartGame) begin
            score_d    = '0;
            combo_d    = '0;
            pend_vld_d = 1'b0;
            cnt_d      = 4'd0;
            sat_d      = 1'b0;
            new_high_d = 1'b0;
        end else begin
            if (state_q == S_ADD) begin
                if (add_res[W]) begin
                    score_d = ALL_NINES;
                    sat_d   = 1'b1;
                end else begin
                    score_d = add_res[W-1:0];
                end
                cnt_d = cnt_q - 4'd1;
                if (last_add && pend_vld_q) begin
                    pts_d      = pend_pts_q;
                    cnt_d      = pend_mult_q;
                    pend_vld_d = 1'b0;
                end
            end

            // A hit arriving as the current job retires goes straight to the working registers.
            if (accept) begin
                if ((state_q == S_IDLE) || last_add) begin
                    pts_d = pts_in;
                    cnt_d = mult_q;
                end else begin
                    pend_vld_d  = 1'b1;
                    pend_pts_d  = pts_in;
                    pend_mult_d = mult_q;
                end
            end

            dropped_d = drop;

            if (miss) begin
                combo_d = '0;
            end else if (accept && (combo_q < COMBO_MAX)) begin
                combo_d = combo_q + 1'b1;
            end
        end

        mult_d = 4'(1 + int'(combo_d) / COMBO_STEP);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score_q     <= '0;
            high_q      <= '0;
            combo_q     <= '0;
            mult_q      <= 4'd1;
            pts_q       <= 4'd0;
            cnt_q       <= 4'd0;
            pend_vld_q  <= 1'b0;
            pend_pts_q  <= 4'd0;
            pend_mult_q <= 4'd0;
            dropped_q   <= 1'b0;
            sat_q       <= 1'b0;
            new_high_q  <= 1'b0;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            combo_q     <= combo_d;
            mult_q      <= mult_d;
            pts_q       <= pts_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_pts_q  <= pend_pts_d;
            pend_mult_q <= pend_mult_d;
            dropped_q   <= dropped_d;
            sat_q       <= sat_d;
            new_high_q  <= new_high_d;
        end
    end

    always_comb begin
        scoreBcd   = score_q;
        highBcd    = high_q;
        multiplier = mult_q;
        busy       = (state_q == S_ADD) || pend_vld_q;
        hitDropped = dropped_q;
        saturated  = sat_q;
        newHigh    = new_high_q;
    end

endmodule

// File: tb/tb_combo_score_keeper.sv
// Bench for combo_score_keeper: directed scenarios then random traffic, all checked per cycle
// against a job-queue model of the scoring rules using plain decimal arithmetic.
module tb_combo_score_keeper;

    localparam int DIGITS     = 3;
    localparam int MAX_MULT   = 4;
    localparam int COMBO_STEP = 5;
    localparam int W          = 4 * DIGITS;
    localparam int MAXV       = 999;
    localparam int COMBO_MAX  = COMBO_STEP * (MAX_MULT - 1);

    logic          clk;
    logic          resetN;
    logic          restartGame;
    logic          hit;
    logic [3:0]    hitPoints;
    logic          miss;
    logic [W-1:0]  scoreBcd;
    logic [W-1:0]  highBcd;
    logic [3:0]    multiplier;
    logic          busy;
    logic          hitDropped;
    logic          saturated;
    logic          newHigh;

    combo_score_keeper #(
        .DIGITS    (DIGITS),
        .MAX_MULT  (MAX_MULT),
        .COMBO_STEP(COMBO_STEP)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .restartGame(restartGame),
        .hit        (hit),
        .hitPoints  (hitPoints),
        .miss       (miss),
        .scoreBcd   (scoreBcd),
        .highBcd    (highBcd),
        .multiplier (multiplier),
        .busy       (busy),
        .hitDropped (hitDropped),
        .saturated  (saturated),
        .newHigh    (newHigh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: decimal scores, combo count, and a queue of jobs (points, adds remaining).
    int m_score, m_high, m_combo;
    int q_pts[$];
    int q_rem[$];
    bit m_sat, m_nh, m_drop;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0;
        m_high  = 0;
        m_combo = 0;
        q_pts.delete();
        q_rem.delete();
        m_sat   = 1'b0;
        m_nh    = 1'b0;
        m_drop  = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit h, input int p, input bit m);
        int prev;
        bit gt;
        int mult_pre;
        bit acc;
        prev = m_score;
        gt   = prev > m_high;
        if (gt) m_high = prev;
        if (r) begin
            m_score = 0;
            m_combo = 0;
            q_pts.delete();
            q_rem.delete();
            m_sat  = 1'b0;
            m_nh   = 1'b0;
            m_drop = 1'b0;
        end else begin
            mult_pre = 1 + m_combo / COMBO_STEP;
            acc      = h && (q_pts.size() < 2);
            m_drop   = h && (q_pts.size() == 2);
            if (q_pts.size() > 0) begin
                m_score = m_score + q_pts[0];
                if (m_score > MAXV) begin
                    m_score = MAXV;
                    m_sat   = 1'b1;
                end
                q_rem[0] = q_rem[0] - 1;
                if (q_rem[0] == 0) begin
                    void'(q_pts.pop_front());
                    void'(q_rem.pop_front());
                end
            end
            if (acc) begin
                q_pts.push_back(p > 9 ? 9 : p);
                q_rem.push_back(mult_pre);
            end
            if (m) m_combo = 0;
            else if (acc && m_combo < COMBO_MAX) m_combo = m_combo + 1;
            if (gt) m_nh = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("score",      32'(scoreBcd),   to_bcd(m_score));
        chk("high",       32'(highBcd),    to_bcd(m_high));
        chk("multiplier", 32'(multiplier), 32'(1 + m_combo / COMBO_STEP));
        chk("busy",       32'(busy),       32'(q_pts.size() != 0));
        chk("hitDropped", 32'(hitDropped), 32'(m_drop));
        chk("saturated",  32'(saturated),  32'(m_sat));
        chk("newHigh",    32'(newHigh),    32'(m_nh));
    endtask

    task automatic cycle(input bit r, input bit h, input logic [3:0] p, input bit m);
        restartGame = r;
        hit         = h;
        hitPoints   = p;
        miss        = m;
        @(posedge clk);
        model_step(r, h, int'(p), m);
        #1;
        check_all();
        restartGame = 1'b0;
        hit         = 1'b0;
        miss        = 1'b0;
    endtask

    task automatic hit_wait(input logic [3:0] p, input bit m);
        cycle(1'b0, 1'b1, p, m);
        for (int k = 0; k < 20 && q_pts.size() != 0; k++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        resetN      = 1'b0;
        restartGame = 1'b0;
        hit         = 1'b0;
        hitPoints   = 4'd0;
        miss        = 1'b0;
        model_reset();

        #12;
        chk("rst_score", 32'(scoreBcd), 32'h0);
        chk("rst_high",  32'(highBcd),  32'h0);
        chk("rst_mult",  32'(multiplier), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_sat",   32'(saturated), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Combo growth: five single points lift the multiplier to 2
        for (int i = 0; i < 5; i++) hit_wait(4'd1, 1'b0);
        chk("five_hits_score", 32'(scoreBcd), 32'h005);
        chk("five_hits_mult",  32'(multiplier), 32'd2);
        hit_wait(4'd3, 1'b0);
        chk("sixth_hit_score", 32'(scoreBcd), 32'h011);

        // Decimal carry across two digits
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) hit_wait(4'd9, 1'b1);
        hit_wait(4'd8, 1'b1);
        chk("pre_carry", 32'(scoreBcd), 32'h098);
        hit_wait(4'd5, 1'b0);
        chk("carry_score", 32'(scoreBcd), 32'h103);
        chk("carry_sat",   32'(saturated), 32'd0);

        // Queueing at multiplier 3: processed, pending, dropped
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) hit_wait(4'd0, 1'b0);
        chk("queue_mult_pre", 32'(multiplier), 32'd3);
        busy_cnt = 0;
        cycle(1'b0, 1'b1, 4'd1, 1'b0);
        busy_cnt += int'(busy);
        cycle(1'b0, 1'b1, 4'd1, 1'b0);
        busy_cnt += int'(busy);
        cycle(1'b0, 1'b1, 4'd1, 1'b0);
        busy_cnt += int'(busy);
        chk("queue_dropped", 32'(hitDropped), 32'd1);
        for (int k = 0; k < 20 && busy; k++) begin
            cycle(1'b0, 1'b0, 4'd0, 1'b0);
            busy_cnt += int'(busy);
        end
        chk("queue_busy_len", 32'(busy_cnt), 32'd6);
        chk("queue_score",    32'(scoreBcd), 32'h006);
        chk("queue_mult",     32'(multiplier), 32'd3);

        // Miss with hit: scored at the old multiplier, combo then cleared
        hit_wait(4'd2, 1'b1);
        chk("miss_hit_score", 32'(scoreBcd), 32'h012);
        chk("miss_mult",      32'(multiplier), 32'd1);
        hit_wait(4'd2, 1'b0);
        chk("after_miss_score", 32'(scoreBcd), 32'h014);

        // Asynchronous reset in the middle of an add sequence
        cycle(1'b0, 1'b1, 4'd9, 1'b0);
        cycle(1'b0, 1'b1, 4'd9, 1'b0);
        #3;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        resetN = 1'b1;

        // High score persists over restart and is beaten later
        for (int i = 0; i < 13; i++) hit_wait(4'd9, 1'b1);
        hit_wait(4'd3, 1'b1);
        chk("reach_120", 32'(scoreBcd), 32'h120);
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        chk("restart_high",  32'(highBcd), 32'h120);
        chk("restart_score", 32'(scoreBcd), 32'h000);
        chk("restart_nh",    32'(newHigh), 32'd0);
        for (int i = 0; i < 13; i++) hit_wait(4'd9, 1'b1);
        hit_wait(4'd4, 1'b1);
        chk("reach_121_high", 32'(highBcd), 32'h120);
        chk("reach_121_nh",   32'(newHigh), 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 1'b0);
        chk("beat_high", 32'(highBcd), 32'h121);
        chk("beat_nh",   32'(newHigh), 32'd1);

        // Saturation at all nines
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 110; i++) hit_wait(4'd9, 1'b1);
        hit_wait(4'd7, 1'b1);
        chk("pre_sat", 32'(scoreBcd), 32'h997);
        hit_wait(4'd5, 1'b1);
        chk("sat_score", 32'(scoreBcd), 32'h999);
        chk("sat_flag",  32'(saturated), 32'd1);
        hit_wait(4'd9, 1'b0);
        chk("sat_hold", 32'(scoreBcd), 32'h999);
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        chk("sat_restart_score", 32'(scoreBcd), 32'h000);
        chk("sat_restart_flag",  32'(saturated), 32'd0);
        chk("sat_restart_high",  32'(highBcd), 32'h999);

        // Random traffic including out-of-range points, misses and restarts
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
